// File: rtl/sad_pkg.sv
// ----------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the SAD search controller:
//   DEFAULT_SAD_W / DEFAULT_CW : default SAD and coordinate widths
//   state_t                    : controller FSM states
//   tag_t                      : {x,y} candidate tag layout for the default
//                                coordinate width
// ----------------------------------------------------------------------------
package sad_pkg;

  localparam int DEFAULT_SAD_W = 12;
  localparam int DEFAULT_CW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEFAULT_CW-1:0] x;
    logic [DEFAULT_CW-1:0] y;
  } tag_t;

endpackage

// File: rtl/sad_search_ctrl_if.sv
// ----------------------------------------------------------------------------
// sad_search_ctrl_if
// Candidate/result channel between the search controller and the SAD datapath.
//   cand_valid/cand_ready : candidate handshake, cand_x/cand_y the position
//   sad_valid/sad         : in-order SAD results returned by the datapath
// Modports: master = controller side, slave = datapath side.
// ----------------------------------------------------------------------------
interface sad_search_ctrl_if #(
  parameter int CW    = sad_pkg::DEFAULT_CW,
  parameter int SAD_W = sad_pkg::DEFAULT_SAD_W
);

  logic             cand_valid;
  logic             cand_ready;
  logic [CW-1:0]    cand_x;
  logic [CW-1:0]    cand_y;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;

  modport master (
    output cand_valid, cand_x, cand_y,
    input  cand_ready, sad_valid, sad
  );

  modport slave (
    input  cand_valid, cand_x, cand_y,
    output cand_ready, sad_valid, sad
  );

endinterface

// File: rtl/sad_tag_fifo.sv
// ----------------------------------------------------------------------------
// sad_tag_fifo
// Synchronous FIFO holding the {x,y} tags of candidates still in the datapath.
// DEPTH must be a power of two so the pointers wrap naturally.
//   clk, rst_n           : clock, asynchronous active-low reset (flushes)
//   push, push_data      : write one tag (ignored when full)
//   pop, pop_data        : drop the head tag (ignored when empty); pop_data is
//                          the current head, valid whenever !empty
//   full, empty, count   : occupancy status
// Push and pop in the same cycle are both performed.
// ----------------------------------------------------------------------------
module sad_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Tag storage; cleared on reset so a flushed FIFO never exposes stale tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// ----------------------------------------------------------------------------
// sad_search_ctrl
// Walks every candidate block position of a SEARCH_W x SEARCH_H window in
// raster order, issues one candidate per handshake to the SAD datapath,
// matches the in-order results against a tag FIFO and keeps the minimum SAD.
//   Clk, Reset : clock, asynchronous active-low reset
//   start      : begin a search (only looked at in IDLE)
//   dp         : candidate/result channel (master side)
//   busy       : search in progress (ISSUE or DRAIN)
//   done       : one-cycle pulse once the last result has been absorbed
//   best_x/y   : position of the minimum SAD, best_sad its value
//   err        : sticky, a result arrived with no candidate outstanding
// All outputs are registered.
// ----------------------------------------------------------------------------
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int SEARCH_W = 61,
  parameter int SEARCH_H = 61,
  parameter int CW       = DEFAULT_CW,
  parameter int SAD_W    = DEFAULT_SAD_W,
  parameter int MAX_OUT  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  sad_search_ctrl_if.master    dp,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        best_x,
  output logic [CW-1:0]        best_y,
  output logic [SAD_W-1:0]     best_sad,
  output logic                 err
);

  localparam int TAG_W = 2 * CW;
  localparam int OCC_W = $clog2(MAX_OUT) + 1;

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      x_r;
  logic [CW-1:0]      y_r;
  logic               cand_valid_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic [CW-1:0]      best_x_r;
  logic [CW-1:0]      best_y_r;
  logic [SAD_W-1:0]   best_sad_r;

  logic               cand_valid_next_s;
  logic               busy_next_s;
  logic               done_next_s;
  logic               active_s;
  logic               start_ok_s;
  logic               hs_s;
  logic               last_s;
  logic               pop_s;
  logic               spurious_s;
  logic               better_s;
  logic [TAG_W-1:0]   push_tag_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [OCC_W-1:0]   occ_s;
  logic [OCC_W-1:0]   occ_next_s;

  assign active_s   = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
  assign start_ok_s = (state_r == ST_IDLE) && start;
  // cand_valid_r is only ever high in ISSUE with room in the FIFO
  assign hs_s       = cand_valid_r && dp.cand_ready;
  assign last_s     = (x_r == CW'(SEARCH_W - 1)) && (y_r == CW'(SEARCH_H - 1));
  assign pop_s      = dp.sad_valid && active_s && !fifo_empty_s;
  assign spurious_s = dp.sad_valid && !pop_s;
  assign better_s   = pop_s && (dp.sad < best_sad_r);
  assign push_tag_s = {x_r, y_r};

  sad_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk       (Clk),
    .rst_n     (Reset),
    .push      (hs_s),
    .push_data (push_tag_s),
    .pop       (pop_s),
    .pop_data  (head_tag_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (occ_s)
  );

  // Occupancy after this edge; lets cand_valid be registered yet exact
  always_comb begin
    occ_next_s = occ_s;
    if (hs_s && !pop_s) begin
      occ_next_s = occ_s + OCC_W'(1);
    end else if (pop_s && !hs_s) begin
      occ_next_s = occ_s - OCC_W'(1);
    end else begin
      occ_next_s = occ_s;
    end
  end

  // FSM next-state and next-output decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hs_s && last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // The last pop and the move to DONE share the same edge
        if (fifo_empty_s || (pop_s && (occ_s == OCC_W'(1)))) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    cand_valid_next_s = (state_next_s == ST_ISSUE) && (occ_next_s != OCC_W'(MAX_OUT));
    busy_next_s       = (state_next_s == ST_ISSUE) || (state_next_s == ST_DRAIN);
    done_next_s       = (state_next_s == ST_DONE);
  end

  // FSM state and registered status outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= ST_IDLE;
      cand_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cand_valid_r <= cand_valid_next_s;
      busy_r       <= busy_next_s;
      done_r       <= done_next_s;
    end
  end

  // Raster position counters; they only move on a handshake so the
  // presented candidate stays put while the datapath stalls
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_r <= '0;
      y_r <= '0;
    end else if (start_ok_s) begin
      x_r <= '0;
      y_r <= '0;
    end else if (hs_s) begin
      if (x_r == CW'(SEARCH_W - 1)) begin
        x_r <= '0;
        if (y_r == CW'(SEARCH_H - 1)) begin
          y_r <= '0;
        end else begin
          y_r <= y_r + CW'(1);
        end
      end else begin
        x_r <= x_r + CW'(1);
      end
    end
  end

  // Minimum tracker; strict compare keeps the earliest raster position on ties
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      best_x_r   <= '0;
      best_y_r   <= '0;
      best_sad_r <= {SAD_W{1'b1}};
    end else if (start_ok_s) begin
      best_x_r   <= '0;
      best_y_r   <= '0;
      best_sad_r <= {SAD_W{1'b1}};
    end else if (better_s) begin
      best_x_r   <= head_tag_s[TAG_W-1 -: CW];
      best_y_r   <= head_tag_s[CW-1:0];
      best_sad_r <= dp.sad;
    end
  end

  // Sticky protocol error; a result coinciding with start still flags
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= spurious_s;
    end else if (spurious_s) begin
      err_r <= 1'b1;
    end
  end

  assign dp.cand_valid = cand_valid_r;
  assign dp.cand_x     = x_r;
  assign dp.cand_y     = y_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign best_x        = best_x_r;
  assign best_y        = best_y_r;
  assign best_sad      = best_sad_r;
  assign err           = err_r;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sad_search_ctrl
// Drives a 4x3 search window through sad_search_ctrl with a behavioural
// datapath (fixed-latency, in-order result queue) and compares every output
// against a reference minimum computed directly from the SAD table.
// ----------------------------------------------------------------------------
module tb_sad_search_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int N    = W * H;
  localparam int MO   = 8;
  localparam int TCW  = 6;
  localparam int TSW  = 12;
  localparam int ALL1 = (1 << TSW) - 1;

  logic           Clk   = 1'b0;
  logic           Reset = 1'b0;
  logic           start = 1'b0;
  logic           busy;
  logic           done;
  logic           err;
  logic [TCW-1:0] best_x;
  logic [TCW-1:0] best_y;
  logic [TSW-1:0] best_sad;

  sad_search_ctrl_if #(.CW(TCW), .SAD_W(TSW)) dp_if ();

  sad_search_ctrl #(
    .SEARCH_W (W),
    .SEARCH_H (H),
    .CW       (TCW),
    .SAD_W    (TSW),
    .MAX_OUT  (MO)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .dp       (dp_if),
    .busy     (busy),
    .done     (done),
    .best_x   (best_x),
    .best_y   (best_y),
    .best_sad (best_sad),
    .err      (err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    int t;
  } flight_t;

  int      n_checks = 0;
  int      n_fails  = 0;
  int      sad_tab[N];
  flight_t inflight[$];

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: raster scan with strict less-than, starting from all-ones
  task automatic ref_best(output int rx, output int ry, output int rs);
    rs = ALL1;
    rx = 0;
    ry = 0;
    for (int i = 0; i < N; i++) begin
      if (sad_tab[i] < rs) begin
        rs = sad_tab[i];
        rx = i % W;
        ry = i / W;
      end
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < N; i++) sad_tab[i] = v;
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < N; i++) sad_tab[i] = int'($urandom_range(maxv));
  endtask

  task automatic check_reset_values(input string name);
    check_value({name, ":cand_valid"}, int'(dp_if.cand_valid), 0);
    check_value({name, ":busy"},       int'(busy), 0);
    check_value({name, ":done"},       int'(done), 0);
    check_value({name, ":err"},        int'(err), 0);
    check_value({name, ":cand_x"},     int'(dp_if.cand_x), 0);
    check_value({name, ":cand_y"},     int'(dp_if.cand_y), 0);
    check_value({name, ":best_x"},     int'(best_x), 0);
    check_value({name, ":best_y"},     int'(best_y), 0);
    check_value({name, ":best_sad"},   int'(best_sad), ALL1);
  endtask

  // One complete search against the behavioural datapath
  task automatic run_search(input string name, input int lat, input int rdy_pct,
                            input int glitch_cyc, input bit expect_single);
    int issued, returned, cyc, final_cyc, max_out, rx, ry, rs, px, py;
    bit sv, hs, stalled, done_now;
    issued = 0; returned = 0; cyc = 0; final_cyc = -10; max_out = 0;
    px = 0; py = 0; stalled = 1'b0; done_now = 1'b0;
    ref_best(rx, ry, rs);
    inflight.delete();
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    while (cyc < 600) begin
      done_now = (cyc == final_cyc + 1);
      check_value({name, ":done"},       int'(done), int'(done_now));
      check_value({name, ":busy"},       int'(busy), done_now ? 0 : 1);
      check_value({name, ":cand_valid"}, int'(dp_if.cand_valid),
                  int'((issued < N) && (inflight.size() < MO)));
      check_value({name, ":err"},        int'(err), 0);
      if (stalled) begin
        check_value({name, ":hold_x"}, int'(dp_if.cand_x), px);
        check_value({name, ":hold_y"}, int'(dp_if.cand_y), py);
      end
      if (done || done_now) break;
      dp_if.cand_ready = ($urandom_range(99) < rdy_pct);
      sv = 1'b0;
      if (inflight.size() > 0) begin
        if (cyc - inflight[0].t >= lat) sv = 1'b1;
      end
      dp_if.sad_valid = sv;
      if (sv) dp_if.sad = TSW'(sad_tab[inflight[0].y * W + inflight[0].x]);
      else    dp_if.sad = '0;
      start = (cyc == glitch_cyc);
      hs = dp_if.cand_valid && dp_if.cand_ready;
      if (sv) begin
        void'(inflight.pop_front());
        returned++;
        if (returned == N) final_cyc = cyc;
      end
      if (hs) begin
        check_value({name, ":issue_x"}, int'(dp_if.cand_x), issued % W);
        check_value({name, ":issue_y"}, int'(dp_if.cand_y), issued / W);
        inflight.push_back('{x: issued % W, y: issued / W, t: cyc});
        issued++;
      end
      if (inflight.size() > max_out) max_out = inflight.size();
      stalled = dp_if.cand_valid && !dp_if.cand_ready;
      px = int'(dp_if.cand_x);
      py = int'(dp_if.cand_y);
      @(posedge Clk); #1;
      cyc++;
    end
    dp_if.cand_ready = 1'b0;
    dp_if.sad_valid  = 1'b0;
    dp_if.sad        = '0;
    start            = 1'b0;
    check_value({name, ":finished"}, int'(cyc < 600), 1);
    check_value({name, ":best_x"},   int'(best_x), rx);
    check_value({name, ":best_y"},   int'(best_y), ry);
    check_value({name, ":best_sad"}, int'(best_sad), rs);
    if (expect_single) check_value({name, ":max_outstanding"}, max_out, 1);
    else               check_value({name, ":outstanding_le_max"}, int'(max_out <= MO), 1);
    @(posedge Clk); #1;
    check_value({name, ":done_one_cycle"}, int'(done), 0);
    check_value({name, ":idle_busy"},      int'(busy), 0);
    check_value({name, ":best_hold"},      int'(best_sad), rs);
  endtask

  // A result in IDLE must flag err and leave the winner alone
  task automatic spurious_idle();
    int rx, ry, rs;
    ref_best(rx, ry, rs);
    dp_if.sad_valid = 1'b1;
    dp_if.sad       = '0;
    @(posedge Clk); #1;
    dp_if.sad_valid = 1'b0;
    check_value("spurious:err",      int'(err), 1);
    check_value("spurious:best_x",   int'(best_x), rx);
    check_value("spurious:best_y",   int'(best_y), ry);
    check_value("spurious:best_sad", int'(best_sad), rs);
    check_value("spurious:busy",     int'(busy), 0);
  endtask

  // Reset in the middle of ISSUE after five handshakes
  task automatic reset_mid_issue();
    int  hs_cnt;
    bit  popped;
    hs_cnt = 0;
    popped = 1'b0;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    dp_if.cand_ready = 1'b1;
    for (int c = 0; c < 40 && hs_cnt < 5; c++) begin
      dp_if.sad_valid = (hs_cnt == 2) && !popped;
      dp_if.sad       = '0;
      if (dp_if.sad_valid) popped = 1'b1;
      if (dp_if.cand_valid) hs_cnt++;
      @(posedge Clk); #1;
    end
    dp_if.cand_ready = 1'b0;
    dp_if.sad_valid  = 1'b0;
    check_value("rst_mid:handshakes", hs_cnt, 5);
    check_value("rst_mid:best_before", int'(best_sad), 0);
    check_value("rst_mid:busy_before", int'(busy), 1);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge Clk);
    Reset = 1'b1;
    inflight.delete();
    @(posedge Clk); #1;
  endtask

  initial begin
    dp_if.cand_ready = 1'b0;
    dp_if.sad_valid  = 1'b0;
    dp_if.sad        = '0;
    #12;
    check_reset_values("por");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;

    fill_const(100);
    sad_tab[1 * W + 2] = 7;
    run_search("basic", 3, 100, -1, 1'b0);
    check_value("basic:win_x",   int'(best_x), 2);
    check_value("basic:win_y",   int'(best_y), 1);
    check_value("basic:win_sad", int'(best_sad), 7);

    fill_const(9);
    sad_tab[0 * W + 1] = 5;
    sad_tab[2 * W + 3] = 5;
    run_search("tie", 3, 100, -1, 1'b0);
    check_value("tie:win_x", int'(best_x), 1);
    check_value("tie:win_y", int'(best_y), 0);

    spurious_idle();

    fill_random(40);
    run_search("backpressure", 20, 50, 6, 1'b0);

    fill_random(300);
    run_search("pushpop", 1, 100, -1, 1'b1);

    fill_const(ALL1);
    run_search("all_ones", 2, 70, -1, 1'b0);

    reset_mid_issue();
    fill_random(60);
    run_search("after_reset", 4, 80, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Sequencing controller for the 16-lane SAD datapath (16 absolute-difference units, 15-adder reduction tree, per-lane data memories). On `start` it walks every candidate block position of a search window in raster order. It issues one candidate per accepted handshake to the datapath and collects the in-order SAD results. It tracks the minimum SAD and its position, then reports the winner with a one-cycle `done` pulse.

## Interface
- `SEARCH_W`, 61: candidate columns (x = 0..SEARCH_W-1)
- `SEARCH_H`, 61: candidate rows (y = 0..SEARCH_H-1)
- `CW`, 6: coordinate width; must hold SEARCH_W-1 and SEARCH_H-1
- `SAD_W`, 12: SAD width (16 lanes x 8-bit abs diff, max 4080)
- `MAX_OUT`, 8: maximum candidates in flight in the datapath (power of two)
- `Clk`  input  1  sole clock, rising edge
- `Reset`  input  1  asynchronous, active-low reset
- `start`  input  1  begin a search; sampled only in IDLE
- `cand_valid`  output  1  candidate position presented to datapath
- `cand_ready`  input  1  datapath accepts candidate
- `cand_x`, `cand_y`  output  CW  candidate position
- `sad_valid`  input  1  one SAD result, in issue order
- `sad`  input  SAD_W  SAD result value
- `busy`  output  1  high in ISSUE and DRAIN
- `done`  output  1  one-cycle completion pulse
- `best_x`, `best_y`  output  CW  position of the minimum SAD
- `best_sad`  output  SAD_W  minimum SAD
- `err`  output  1  sticky: `sad_valid` arrived with no candidate outstanding

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when `start` is high, clear the x/y counters, set `best_sad` to all-ones, set `best_x`/`best_y` to 0, clear `err`, and go to ISSUE.
- ISSUE:
  - `cand_valid` = 1 when the tag FIFO is not full.
  - A handshake (`cand_valid && cand_ready`) pushes {x,y} into the tag FIFO and advances the counters. x increments first; when x wraps from SEARCH_W-1 to 0, y increments.
  - The handshake on (SEARCH_W-1, SEARCH_H-1) moves the FSM to DRAIN.
- DRAIN: `cand_valid` = 0. The FSM waits until the tag FIFO is empty, then goes to DONE.
- DONE: `done` = 1 for one cycle, then the FSM returns to IDLE. `best_*` hold until the next accepted `start`.
- Every `sad_valid` in ISSUE or DRAIN pops one tag.
  - If `sad < best_sad` (strict), load `best_sad`, `best_x` and `best_y` from `sad` and the tag.
  - Ties keep the earlier raster position.
- A push and a pop in the same cycle are both performed; FIFO occupancy is unchanged.
- `sad_valid` with the FIFO empty, or in IDLE/DONE:
  - Sets `err`. Nothing is popped. `best_*` is unchanged.
- `start` while not IDLE is ignored.
- `cand_x`/`cand_y` are stable while `cand_valid` is high and `cand_ready` is low.
- Transition condition into DONE:
  - FIFO empty, or becoming empty through a pop this cycle.
  - All candidates issued.
  - Consequence: the final pop and the transition to DONE occur on the same edge.

## Timing
- Reset values:
  - FSM = IDLE.
  - `cand_valid`, `busy`, `done`, `err` = 0.
  - `cand_x`, `cand_y`, `best_x`, `best_y` = 0.
  - `best_sad` = all-ones.
  - FIFO empty.
- `start` sampled at edge N gives `cand_valid` = 1 and `busy` = 1 in cycle N+1.
- Issue rate: up to 1 candidate per cycle. Throttling comes only from `cand_ready` or MAX_OUT.
- The final `sad_valid` consumed at edge M gives `done` = 1 and updated `best_*` in cycle M+1. `busy` = 0 in that same cycle.
- Reset asserted mid-search:
  - Immediate return to the reset values. The FIFO is flushed.
  - Results still in the datapath and arriving after reset release raise `err`. The datapath shares this reset, so this is not expected.

## Structure
- Package `sad_pkg`: `SAD_W`, `CW` defaults, FSM state enum, and a packed tag struct {x,y}.
- Sub-module `sad_tag_fifo`: synchronous FIFO, MAX_OUT deep and 2*CW wide, with `full`/`empty` outputs and simultaneous push/pop support.
- The FSM, counters and minimum tracker stay in `sad_search_ctrl`.

## Test plan
- Basic search (SEARCH_W=4, SEARCH_H=3, `cand_ready` tied 1, datapath model with 3-cycle latency, SAD = 100 except 7 at (2,1)):
  - 12 handshakes in raster order.
  - `done` pulses once with `best_x`=2, `best_y`=1, `best_sad`=7.
- Tie: SAD = 5 at (1,0) and at (3,2), everything else 9 → `best_x`=1, `best_y`=0.
- Backpressure and full FIFO:
  - Stimulus: `cand_ready` random 50%, datapath latency 20 cycles, MAX_OUT=8.
  - Required: never more than 8 outstanding; `cand_x`/`cand_y` held while stalled; correct minimum at the end.
- Simultaneous push/pop: 1-cycle datapath latency with continuous ready → FIFO occupancy stays at 1, and `done` follows the last result by one cycle.
- Protocol errors:
  - Spurious `sad_valid` in IDLE → `err`=1 and `best_*` unchanged.
  - `start` in mid-search → ignored.
- Reset mid-ISSUE: assert `Reset` low after 5 handshakes → all outputs return to reset values asynchronously; a new `start` completes a full, correct search.
